// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, arbiter FSM states, word type.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DSERV = 3'd1,
        ISERV = 3'd2,
        DHIT  = 3'd3,
        IHIT  = 3'd4,
        ERR   = 3'd5
    } arb_state_t;

    // True while the arbiter owns the RAM port for an access
    function automatic logic is_serv(input arb_state_t s);
        return (s == DSERV) || (s == ISERV);
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the CPU-side and RAM-side arbiter signals.
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    logic      dREN;
    logic      dWEN;
    word_t     iaddr;
    word_t     daddr;
    word_t     dstore;
    logic      ihit;
    logic      dhit;
    word_t     iload;
    word_t     dload;
    logic      merr;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport arb (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output ihit, dhit, iload, dload, merr, ramREN, ramWEN, ramaddr, ramstore
    );

    modport cpu (
        output iREN, dREN, dWEN, iaddr, daddr, dstore,
        input  ihit, dhit, iload, dload, merr
    );

    modport ram (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );

endinterface

// File: rtl/watchdog_counter.sv
// Saturating per-access cycle counter; flags the last allowed cycle.
module watchdog_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] SAT  = W'(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Clear outside service, count service cycles, hold at saturation
    always_ff @(posedge CLK) begin
        if (RST || clr)
            count <= '0;
        else if (en && (count != SAT))
            count <= count + W'(1);
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data accesses beat instruction fetches,
// registered hit pulses, sticky error on RAM ERROR or watchdog expiry.
module memory_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        merr
);
    import cpu_types_pkg::*;

    arb_state_t state, next_state;
    ramstate_t  rs;
    logic       serv;
    logic       timeout;
    logic       ld_i, ld_d;

    assign rs   = ramstate_t'(ramstate);
    assign serv = is_serv(state);

    // Counter is zero on the first cycle of every service state
    watchdog_counter #(.TIMEOUT(TIMEOUT)) u_wdog (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (~serv),
        .en      (serv),
        .expired (timeout)
    );

    // Next state, RAM port drive, hit decode and load-capture strobes
    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        ihit       = 1'b0;
        dhit       = 1'b0;
        merr       = 1'b0;
        ld_i       = 1'b0;
        ld_d       = 1'b0;
        case (state)
            IDLE: begin
                if (dREN || dWEN)
                    next_state = DSERV;
                else if (iREN)
                    next_state = ISERV;
            end
            DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;   // write wins when both are raised
                if (rs == ACCESS) begin
                    next_state = DHIT;
                    ld_d       = dREN & ~dWEN;
                end else if (rs == ERROR || timeout) begin
                    next_state = ERR;
                end
            end
            ISERV: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (rs == ACCESS) begin
                    next_state = IHIT;
                    ld_i       = 1'b1;
                end else if (rs == ERROR || timeout) begin
                    next_state = ERR;
                end
            end
            DHIT: begin
                dhit       = 1'b1;
                next_state = IDLE;
            end
            IHIT: begin
                ihit       = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                merr = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register and load-data capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            iload <= '0;
            dload <= '0;
        end else begin
            state <= next_state;
            if (ld_i) iload <= ramload;
            if (ld_d) dload <= ramload;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: behavioural RAM with programmable wait states,
// vector table plus hand sequences for reset, RAM error and timeout.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    memory_arbiter_if bus();

    memory_arbiter #(.TIMEOUT(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (bus.iREN),
        .iaddr    (bus.iaddr),
        .dREN     (bus.dREN),
        .dWEN     (bus.dWEN),
        .daddr    (bus.daddr),
        .dstore   (bus.dstore),
        .ihit     (bus.ihit),
        .dhit     (bus.dhit),
        .iload    (bus.iload),
        .dload    (bus.dload),
        .ramREN   (bus.ramREN),
        .ramWEN   (bus.ramWEN),
        .ramaddr  (bus.ramaddr),
        .ramstore (bus.ramstore),
        .ramload  (bus.ramload),
        .ramstate (bus.ramstate),
        .merr     (bus.merr)
    );

    // ---------------- behavioural RAM ----------------
    word_t mem [0:255];
    int    busy_cnt;
    int    cfg_waits;
    logic  cfg_stuck, cfg_err;
    logic  en;

    assign en          = bus.ramREN | bus.ramWEN;
    assign bus.ramload = mem[bus.ramaddr[9:2]];

    // RAM answers ACCESS after cfg_waits BUSY cycles of a held enable
    always_comb begin
        bus.ramstate = FREE;
        if (en) begin
            if (cfg_err)
                bus.ramstate = ERROR;
            else if (cfg_stuck || busy_cnt < cfg_waits)
                bus.ramstate = BUSY;
            else
                bus.ramstate = ACCESS;
        end
    end

    // Wait-state counter, write port and preload
    always @(posedge CLK) begin
        if (RST) begin
            busy_cnt <= 0;
            mem[16]  <= 32'h8C22_0004;   // 0x40
            mem[17]  <= 32'h1111_2222;   // 0x44
            mem[64]  <= 32'hDEAD_BEEF;   // 0x100
        end else begin
            if (en && bus.ramstate != ACCESS) busy_cnt <= busy_cnt + 1;
            else                              busy_cnt <= 0;
            if (bus.ramWEN && bus.ramstate == ACCESS)
                mem[bus.ramaddr[9:2]] <= bus.ramstore;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic  is_d;
        word_t val;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic  iren, dren, dwen;
        word_t iaddr, daddr, dstore;
        int    waits;
        int    lat;      // cycles from request to first hit
        int    nren;     // cycles with ramREN high
        int    nwen;     // cycles with ramWEN high
        word_t exp_d, exp_i;
    } vec_t;

    // Drive one request set, score hits against the queue, drop each request on its hit
    task automatic run_vec(input int idx, input vec_t v);
        int    cyc = 0, hits = 0, nhit, ren = 0, wen = 0, first = -1;
        logic  dpend;
        exp_t  e;
        nhit  = ((v.dren | v.dwen) ? 1 : 0) + (v.iren ? 1 : 0);
        dpend = v.dren | v.dwen;
        if (dpend)  sb.push_back('{1'b1, v.exp_d});
        if (v.iren) sb.push_back('{1'b0, v.exp_i});
        cfg_waits  = v.waits;
        bus.iREN   = v.iren;
        bus.iaddr  = v.iaddr;
        bus.dREN   = v.dren;
        bus.dWEN   = v.dwen;
        bus.daddr  = v.daddr;
        bus.dstore = v.dstore;
        while (hits < nhit && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            if (bus.ramREN) ren++;
            if (bus.ramWEN) wen++;
            if (en) chk($sformatf("v%0d ramaddr", idx), bus.ramaddr, dpend ? v.daddr : v.iaddr);
            if (bus.ramWEN) chk($sformatf("v%0d ramstore", idx), bus.ramstore, v.dstore);
            if (bus.ihit || bus.dhit) begin
                if (first < 0) first = cyc;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL v%0d unexpected hit ihit=%b dhit=%b", idx, bus.ihit, bus.dhit);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d hit_kind", idx), bus.dhit, e.is_d);
                    chk($sformatf("v%0d load", idx), bus.dhit ? bus.dload : bus.iload, e.val);
                end
                hits++;
                if (bus.dhit) begin
                    bus.dREN = 1'b0; bus.dWEN = 1'b0; dpend = 1'b0;
                end else begin
                    bus.iREN = 1'b0;
                end
            end
        end
        if (hits < nhit) begin
            checks++; errors++;
            $display("FAIL v%0d hit timeout: got %0d hits expected %0d", idx, hits, nhit);
            sb.delete();
        end
        chk($sformatf("v%0d latency", idx), first, v.lat);
        chk($sformatf("v%0d ren_cycles", idx), ren, v.nren);
        chk($sformatf("v%0d wen_cycles", idx), wen, v.nwen);
        @(negedge CLK);
        chk($sformatf("v%0d idle_quiet", idx), {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN}, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ctrl"},  {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.merr}, 0);
        chk({tag, " addr"},  {bus.ramaddr, bus.ramstore}, 0);
        chk({tag, " loads"}, {bus.iload, bus.dload}, 0);
    endtask

    vec_t vecs[7];

    initial begin
        int   mcyc, mfirst, mren, mhits;
        vec_t v;

        //             iren  dren  dwen  iaddr       daddr       dstore        w  lat ren wen exp_d          exp_i
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40,  32'h0,   32'h0,          0, 2, 1, 0, 32'h0,          32'h8C22_0004};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h44,  32'h100, 32'h0,          0, 2, 2, 0, 32'hDEAD_BEEF,  32'h1111_2222};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0,   32'h200, 32'h1234_5678,  3, 5, 0, 4, 32'hDEAD_BEEF,  32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h200, 32'h0,          1, 3, 2, 0, 32'h1234_5678,  32'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h300, 32'hCAFE_F00D,  0, 2, 0, 1, 32'h1234_5678,  32'h0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h300, 32'h0,          2, 4, 3, 0, 32'hCAFE_F00D,  32'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h300, 32'h0,   32'h0,          4, 6, 5, 0, 32'h0,          32'hCAFE_F00D};

        RST = 1'b1;
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        cfg_waits = 0; cfg_stuck = 1'b0; cfg_err = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_vals("reset");
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset while a data access waits on a BUSY RAM
        cfg_stuck = 1'b1;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h500;
        repeat (3) @(negedge CLK);
        chk("midrst ren",  bus.ramREN,  1);
        chk("midrst addr", bus.ramaddr, 32'h500);
        RST = 1'b1;
        @(negedge CLK);
        chk_reset_vals("midrst");
        RST = 1'b0; bus.dREN = 1'b0; bus.daddr = '0; cfg_stuck = 1'b0;
        v = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 0, 2, 1, 0, 32'h0, 32'h8C22_0004};
        run_vec(7, v);

        // RAM reports ERROR during an instruction fetch
        cfg_err  = 1'b1;
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        @(negedge CLK);
        chk("ramerr serv", {bus.merr, bus.ramREN}, 2'b01);
        @(negedge CLK);
        chk("ramerr err", {bus.merr, bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}, 5'b10000);
        repeat (3) @(negedge CLK);
        chk("ramerr sticky", {bus.merr, bus.ihit}, 2'b10);
        RST = 1'b1; bus.iREN = 1'b0; cfg_err = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        chk("ramerr clear", bus.merr, 0);

        // Watchdog: RAM stuck BUSY on a data read
        cfg_stuck = 1'b1;
        bus.dREN  = 1'b1; bus.daddr = 32'h100;
        mfirst = -1; mren = 0; mhits = 0;
        for (mcyc = 1; mcyc <= 30; mcyc++) begin
            @(negedge CLK);
            if (bus.ramREN) mren++;
            if (bus.ihit || bus.dhit) mhits++;
            if (bus.merr && mfirst < 0) mfirst = mcyc;
        end
        chk("wdog merr_cycle", mfirst, 17);
        chk("wdog serv_cycles", mren, 16);
        chk("wdog no_hits", mhits, 0);
        chk("wdog err_outputs", {bus.merr, bus.ramREN, bus.ramWEN}, 3'b100);
        RST = 1'b1; bus.dREN = 1'b0; cfg_stuck = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        chk_reset_vals("wdog rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
